// File: rtl/fp_div_single.sv
// rtl/fp_div_single.sv - iterative IEEE-754 single-precision divider, c = a / b
// Restoring shift-subtract, RADIX_BITS quotient bits per cycle, truncating, denormals flushed.
module fp_div_single #(
    parameter int RADIX_BITS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] c,
    output logic        dz
);
    localparam int ITER = 25 / RADIX_BITS;

    typedef enum logic [1:0] {IDLE, CALC, PACK, DONE} state_t;

    state_t      state_q, state_d;
    logic        load_q, load_d;
    logic        spec_q, spec_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [24:0] rem_q, rem_d;
    logic [24:0] quot_q, quot_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [9:0]  exp_q, exp_d;
    logic [31:0] c_q, c_d;
    logic        dz_q, dz_d;

    logic [7:0]  ea, eb;
    logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, sgn;
    logic [23:0] mb;
    logic [9:0]  e_raw, e_fin;
    logic [22:0] frac;
    logic [24:0] rem_s, quot_s;

    assign ea     = a_q[30:23];
    assign eb     = b_q[30:23];
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);
    assign a_inf  = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
    assign a_nan  = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
    assign sgn    = a_q[31] ^ b_q[31];
    assign mb     = {1'b1, b_q[22:0]};
    assign e_raw  = {2'b00, ea} - {2'b00, eb} + 10'd127;
    // A quotient below 2^24 means the mantissa ratio was under 1: drop one exponent step.
    assign e_fin  = quot_q[24] ? exp_q : exp_q - 10'd1;
    assign frac   = quot_q[24] ? quot_q[23:1] : quot_q[22:0];

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign c         = c_q;
    assign dz        = dz_q;

    // Remainder stays below 2*mb < 2^25, so the shifted-out top bit is always zero.
    always_comb begin
        rem_s  = rem_q;
        quot_s = quot_q;
        for (int i = 0; i < RADIX_BITS; i++) begin
            if (rem_s >= {1'b0, mb}) begin
                rem_s  = rem_s - {1'b0, mb};
                quot_s = {quot_s[23:0], 1'b1};
            end else begin
                quot_s = {quot_s[23:0], 1'b0};
            end
            rem_s = {rem_s[23:0], 1'b0};
        end
    end

    always_comb begin
        state_d = state_q;
        load_d  = load_q;
        spec_d  = spec_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        c_d     = c_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    load_d  = 1'b1;
                    spec_d  = 1'b0;
                    dz_d    = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (load_q) begin
                    load_d = 1'b0;
                    spec_d = 1'b1;
                    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                        c_d = 32'h7FC00000;
                    end else if (b_zero && !a_inf) begin
                        c_d  = {sgn, 8'hFF, 23'd0};
                        dz_d = 1'b1;
                    end else if (a_inf) begin
                        c_d = {sgn, 8'hFF, 23'd0};
                    end else if (a_zero || b_inf) begin
                        c_d = {sgn, 31'd0};
                    end else begin
                        spec_d = 1'b0;
                        rem_d  = {1'b0, 1'b1, a_q[22:0]};
                        quot_d = 25'd0;
                        cnt_d  = 5'(ITER - 1);
                        exp_d  = e_raw;
                    end
                    // Special results skip the iterations but still pass through PACK.
                    if (spec_d) begin
                        state_d = PACK;
                    end
                end else begin
                    rem_d  = rem_s;
                    quot_d = quot_s;
                    cnt_d  = cnt_q - 5'd1;
                    if (cnt_q == 5'd0) begin
                        state_d = PACK;
                    end
                end
            end
            PACK: begin
                if (!spec_q) begin
                    if ($signed(e_fin) >= 10'sd255) begin
                        c_d = {sgn, 8'hFF, 23'd0};
                    end else if ($signed(e_fin) <= 10'sd0) begin
                        c_d = {sgn, 31'd0};
                    end else begin
                        c_d = {sgn, e_fin[7:0], frac};
                    end
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            load_q  <= 1'b0;
            spec_q  <= 1'b0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            rem_q   <= 25'd0;
            quot_q  <= 25'd0;
            cnt_q   <= 5'd0;
            exp_q   <= 10'd0;
            c_q     <= 32'd0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            spec_q  <= spec_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            c_q     <= c_d;
            dz_q    <= dz_d;
        end
    end
endmodule

// File: tb/tb_fp_div_single.sv
// tb/tb_fp_div_single.sv - directed bench for fp_div_single, RADIX_BITS 1 and 5 side by side
module tb_fp_div_single;
    logic        clk;
    logic        rst1_n, rst5_n;
    logic        in_valid, out_ready;
    logic [31:0] a_i, b_i;
    logic        in_ready1, out_valid1, dz1;
    logic        in_ready5, out_valid5, dz5;
    logic [31:0] c1, c5;
    int          n_assert, n_fail;

    fp_div_single #(.RADIX_BITS(1)) u1 (
        .clk(clk), .rst_n(rst1_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a_i), .b(b_i), .out_valid(out_valid1), .out_ready(out_ready),
        .c(c1), .dz(dz1)
    );

    fp_div_single #(.RADIX_BITS(5)) u5 (
        .clk(clk), .rst_n(rst5_n), .in_valid(in_valid), .in_ready(in_ready5),
        .a(a_i), .b(b_i), .out_valid(out_valid5), .out_ready(out_ready),
        .c(c5), .dz(dz5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic accept(input logic [31:0] av, input logic [31:0] bv);
        a_i      = av;
        b_i      = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [31:0] exp_c, input logic exp_dz,
                                 input int l1, input int l5);
        int lat1, lat5;
        lat1 = -1;
        lat5 = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (out_valid1 && lat1 < 0) lat1 = k;
            if (out_valid5 && lat5 < 0) lat5 = k;
            if (lat1 >= 0 && lat5 >= 0) break;
        end
        chk32({tag, "_lat_r1"}, lat1, l1);
        chk32({tag, "_lat_r5"}, lat5, l5);
        chk32({tag, "_c_r1"}, c1, exp_c);
        chk32({tag, "_c_r5"}, c5, exp_c);
        chk1({tag, "_dz_r1"}, dz1, exp_dz);
        chk1({tag, "_dz_r5"}, dz5, exp_dz);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] exp_c, input logic exp_dz, input int l1, input int l5);
        accept(av, bv);
        expect_result(tag, exp_c, exp_dz, l1, l5);
        drain();
    endtask

    initial begin
        logic saw;
        n_assert  = 0;
        n_fail    = 0;
        rst1_n    = 1'b0;
        rst5_n    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_i       = 32'd0;
        b_i       = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_in_ready_r1", in_ready1, 1'b1);
        chk1("rst_in_ready_r5", in_ready5, 1'b1);
        chk1("rst_out_valid_r1", out_valid1, 1'b0);
        chk1("rst_out_valid_r5", out_valid5, 1'b0);
        chk32("rst_c_r1", c1, 32'h0);
        chk32("rst_c_r5", c5, 32'h0);
        chk1("rst_dz_r1", dz1, 1'b0);
        chk1("rst_dz_r5", dz5, 1'b0);
        rst1_n = 1'b1;
        rst5_n = 1'b1;
        @(posedge clk);
        #1;

        run("one_25_div_0625", 32'h3FA00000, 32'h3F200000, 32'h40000000, 1'b0, 27, 7);
        run("one_third",       32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 27, 7);
        run("one_div_zero",    32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 2, 2);
        run("zero_div_zero",   32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 2, 2);
        run("neg_inf_div_one", 32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b0, 2, 2);
        run("overflow",        32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, 27, 7);
        run("underflow",       32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 27, 7);
        run("exp_255_edge",    32'h7F000000, 32'h3F000000, 32'h7F800000, 1'b0, 27, 7);
        run("exp_1_edge",      32'h00800000, 32'h3F800000, 32'h00800000, 1'b0, 27, 7);
        run("exp_1_third",     32'h01000000, 32'h3FC00000, 32'h00AAAAAA, 1'b0, 27, 7);
        run("six_div_neg15",   32'h40C00000, 32'hBFC00000, 32'hC0800000, 1'b0, 27, 7);
        run("one_div_1ulp",    32'h3F800000, 32'h3F800001, 32'h3F7FFFFE, 1'b0, 27, 7);
        run("nan_operand",     32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 2, 2);
        run("inf_div_inf",     32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 2, 2);
        run("neg_zero_div",    32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 2, 2);
        run("one_div_inf",     32'h3F800000, 32'h7F800000, 32'h00000000, 1'b0, 2, 2);
        run("denorm_flush",    32'h00400000, 32'h3F800000, 32'h00000000, 1'b0, 2, 2);
        run("inf_div_zero",    32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0, 2, 2);

        accept(32'h3FA00000, 32'h3F200000);
        a_i      = 32'h40800000;
        b_i      = 32'h40000000;
        in_valid = 1'b1;
        expect_result("bp_first", 32'h40000000, 1'b0, 27, 7);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk32("bp_hold_c_r1", c1, 32'h40000000);
            chk32("bp_hold_c_r5", c5, 32'h40000000);
            chk1("bp_hold_in_ready_r1", in_ready1, 1'b0);
            chk1("bp_hold_in_ready_r5", in_ready5, 1'b0);
            chk1("bp_hold_valid_r1", out_valid1, 1'b1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk1("bp_drain_idle_r1", in_ready1, 1'b1);
        chk1("bp_drain_idle_r5", in_ready5, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk1("bp_second_taken_r1", in_ready1, 1'b0);
        chk1("bp_second_taken_r5", in_ready5, 1'b0);
        expect_result("bp_second", 32'h40000000, 1'b0, 27, 7);
        drain();

        accept(32'h3FA00000, 32'h3F200000);
        repeat (3) @(posedge clk);
        #1;
        rst5_n = 1'b0;
        #1;
        chk1("abort_in_ready_r5", in_ready5, 1'b1);
        chk1("abort_out_valid_r5", out_valid5, 1'b0);
        chk32("abort_c_r5", c5, 32'h0);
        rst5_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk1("abort_busy_r1", in_ready1, 1'b0);
        rst1_n = 1'b0;
        #1;
        chk1("abort_in_ready_r1", in_ready1, 1'b1);
        chk1("abort_out_valid_r1", out_valid1, 1'b0);
        chk32("abort_c_r1", c1, 32'h0);
        rst1_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid1 || out_valid5) saw = 1'b1;
        end
        chk1("abort_no_out_valid", saw, 1'b0);
        run("after_abort", 32'h40800000, 32'h40000000, 32'h40000000, 1'b0, 27, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
